// File: rtl/rx_frame_parser.sv
// rtl/rx_frame_parser.sv - SOF/CMD/LEN/payload/XOR frame parser with buffered, backpressured emit
// Optional inter-byte timeout: define RX_FRAME_TIMEOUT_EN.
module rx_frame_parser #(
  parameter int MAX_LEN        = 64,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_data,
  input  logic       in_val,
  output logic       in_rdy,
  output logic [7:0] out_cmd,
  output logic [6:0] out_len,
  output logic [7:0] out_data,
  output logic       out_val,
  input  logic       out_rdy,
  output logic       out_last,
  output logic       err_len,
  output logic       err_chk,
  output logic       err_tmo
);

  typedef enum logic [2:0] {S_HUNT, S_CMD, S_LEN, S_PAYLOAD, S_CHK, S_EMIT} state_t;

  localparam int         AW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);
  localparam logic [7:0] SOF       = 8'hA5;

  state_t     state_q, state_d;
  logic [7:0] cmd_q, cmd_d, xor_q, xor_d;
  logic [6:0] len_q, len_d, wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
  logic       err_len_q, err_len_d, err_chk_q, err_chk_d;
  logic [7:0] mem_q [MAX_LEN];
  logic       mem_we, in_xfer, out_xfer, last_beat, tmo_hit;

  // in_rdy is gated by rst so it reads low while reset is held
  assign in_rdy    = !rst && (state_q != S_EMIT);
  assign in_xfer   = in_val && in_rdy;
  assign out_val   = (state_q == S_EMIT);
  assign out_xfer  = out_val && out_rdy;
  assign last_beat = (len_q == 7'd0) || (rd_idx_q == len_q - 7'd1);
  assign out_last  = out_val && last_beat;
  assign out_cmd   = cmd_q;
  assign out_len   = len_q;
  assign out_data  = (len_q == 7'd0) ? 8'h00 : mem_q[rd_idx_q[AW-1:0]];
  assign err_len   = err_len_q;
  assign err_chk   = err_chk_q;

`ifdef RX_FRAME_TIMEOUT_EN
  logic [31:0] tmo_q, tmo_d;
  logic        err_tmo_q;

  always_comb begin
    tmo_d   = 32'd0;
    tmo_hit = 1'b0;
    if ((state_q inside {S_CMD, S_LEN, S_PAYLOAD, S_CHK}) && !in_xfer) begin
      if (tmo_q == 32'(TIMEOUT_CYCLES - 1)) tmo_hit = 1'b1;
      else                                  tmo_d   = tmo_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q     <= 32'd0;
      err_tmo_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      err_tmo_q <= tmo_hit;
    end
  end

  assign err_tmo = err_tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYCLES > 0);
  assign tmo_hit        = 1'b0;
  assign err_tmo        = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    xor_d     = xor_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    err_len_d = 1'b0;
    err_chk_d = 1'b0;
    mem_we    = 1'b0;
    case (state_q)
      S_HUNT: if (in_xfer && in_data == SOF) state_d = S_CMD;
      S_CMD: if (in_xfer) begin
        cmd_d   = in_data;
        xor_d   = in_data;
        state_d = S_LEN;
      end
      S_LEN: if (in_xfer) begin
        if (in_data[7] || in_data > MAX_LEN_B) begin
          err_len_d = 1'b1;
          state_d   = S_HUNT;
        end else begin
          len_d    = in_data[6:0];
          xor_d    = xor_q ^ in_data;
          wr_idx_d = 7'd0;
          rd_idx_d = 7'd0;
          state_d  = (in_data == 8'h00) ? S_CHK : S_PAYLOAD;
        end
      end
      S_PAYLOAD: if (in_xfer) begin
        mem_we   = 1'b1;
        xor_d    = xor_q ^ in_data;
        wr_idx_d = wr_idx_q + 7'd1;
        if (wr_idx_q == len_q - 7'd1) state_d = S_CHK;
      end
      S_CHK: if (in_xfer) begin
        if (in_data == xor_q) state_d = S_EMIT;
        else begin
          err_chk_d = 1'b1;
          state_d   = S_HUNT;
        end
      end
      S_EMIT: if (out_xfer) begin
        if (last_beat) begin
          rd_idx_d = 7'd0;
          state_d  = S_HUNT;
        end else begin
          rd_idx_d = rd_idx_q + 7'd1;
        end
      end
      default: state_d = S_HUNT;
    endcase
    if (tmo_hit) state_d = S_HUNT;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_HUNT;
      cmd_q     <= 8'h00;
      len_q     <= 7'd0;
      xor_q     <= 8'h00;
      wr_idx_q  <= 7'd0;
      rd_idx_q  <= 7'd0;
      err_len_q <= 1'b0;
      err_chk_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      xor_q     <= xor_d;
      wr_idx_q  <= wr_idx_d;
      rd_idx_q  <= rd_idx_d;
      err_len_q <= err_len_d;
      err_chk_q <= err_chk_d;
    end
  end

  // Payload buffer is never cleared; stale bytes are unreachable past len_q
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_idx_q[AW-1:0]] <= in_data;
  end

endmodule

// File: tb/tb_rx_frame_parser.sv
// tb/tb_rx_frame_parser.sv - directed self-checking bench for rx_frame_parser
module tb_rx_frame_parser;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] out_cmd;
  logic [6:0] out_len;
  logic [7:0] out_data;
  logic       out_val;
  logic       out_rdy;
  logic       out_last;
  logic       err_len, err_chk, err_tmo;

  int n_asrt = 0;
  int n_fail = 0;
  int cnt_len = 0, cnt_chk = 0, cnt_tmo = 0, cnt_clash = 0;

`ifdef RX_FRAME_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  rx_frame_parser #(.MAX_LEN(64), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_val(in_val), .in_rdy(in_rdy),
    .out_cmd(out_cmd), .out_len(out_len), .out_data(out_data), .out_val(out_val),
    .out_rdy(out_rdy), .out_last(out_last),
    .err_len(err_len), .err_chk(err_chk), .err_tmo(err_tmo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!rst) begin
      if (err_len) cnt_len++;
      if (err_chk) cnt_chk++;
      if (err_tmo) cnt_tmo++;
      if (out_val && (err_len || err_chk || err_tmo)) cnt_clash++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    in_data = b;
    in_val  = 1'b1;
    tick();
    in_val  = 1'b0;
  endtask

  task automatic expect_beat(input string tag, input logic [7:0] cmd, input logic [6:0] len,
                             input logic [7:0] data, input logic last);
    check({tag, ".val"},  out_val,  1);
    check({tag, ".cmd"},  out_cmd,  cmd);
    check({tag, ".len"},  out_len,  len);
    check({tag, ".data"}, out_data, data);
    check({tag, ".last"}, out_last, last);
    tick();
  endtask

  task automatic drain();
    for (int k = 0; k < 8 && out_val; k++) tick();
    check("drain", out_val, 0);
  endtask

  initial begin
    rst = 1'b1; in_val = 1'b0; in_data = 8'h00; out_rdy = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.in_rdy", in_rdy, 0);
    check("rst.out_val", out_val, 0);
    check("rst.out_last", out_last, 0);
    check("rst.errs", {err_len, err_chk, err_tmo}, 0);
    rst = 1'b0;
    #1;
    check("post_rst.in_rdy", in_rdy, 1);
    out_rdy = 1'b1;

    // basic two-beat frame
    send(8'hA5); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    check("f1.in_rdy_emit", in_rdy, 0);
    expect_beat("f1.b0", 8'h01, 7'd2, 8'h10, 1'b0);
    expect_beat("f1.b1", 8'h01, 7'd2, 8'h20, 1'b1);
    check("f1.done", out_val, 0);
    check("f1.in_rdy_back", in_rdy, 1);

    // bad checksum, then a good frame
    send(8'hA5); send(8'h01); send(8'h02); send(8'h10); send(8'h20); send(8'h34);
    check("chk.pulse", err_chk, 1);
    check("chk.no_val", out_val, 0);
    tick();
    check("chk.pulse_end", err_chk, 0);
    send(8'hA5); send(8'h03); send(8'h01); send(8'h55); send(8'h57);
    expect_beat("f2.b0", 8'h03, 7'd1, 8'h55, 1'b1);
    check("f2.done", out_val, 0);

    // oversize length and bit-7 length; following bytes are noise
    send(8'hA5); send(8'h07); send(8'h41);
    check("len65.pulse", err_len, 1);
    send(8'h11); send(8'h22);
    check("len65.no_val", out_val, 0);
    send(8'hA5); send(8'h07); send(8'h80);
    check("len80.pulse", err_len, 1);
    tick();
    check("len80.no_val", out_val, 0);

    // maximum length 64, payload 0..63, chk = 02^40
    send(8'hA5); send(8'h02); send(8'h40);
    for (int i = 0; i < 64; i++) send(8'(i));
    send(8'h42);
    for (int i = 0; i < 64; i++) expect_beat("len64", 8'h02, 7'd64, 8'(i), i == 63);
    check("len64.done", out_val, 0);

    // zero-length frame
    send(8'hA5); send(8'h09); send(8'h00); send(8'h09);
    expect_beat("len0", 8'h09, 7'd0, 8'h00, 1'b1);
    check("len0.done", out_val, 0);

    // backpressure 1-0-0-1 on a 3-byte frame (chk 0C^03^AA^BB^CC = D2)
    send(8'hA5); send(8'h0C); send(8'h03); send(8'hAA); send(8'hBB); send(8'hCC); send(8'hD2);
    expect_beat("bp.b0", 8'h0C, 7'd3, 8'hAA, 1'b0);
    out_rdy = 1'b0; in_val = 1'b1; in_data = 8'hA5;
    for (int s = 0; s < 2; s++) begin
      tick();
      check("bp.stall.val", out_val, 1);
      check("bp.stall.data", out_data, 8'hBB);
      check("bp.stall.last", out_last, 0);
      check("bp.stall.len", out_len, 3);
      check("bp.stall.in_rdy", in_rdy, 0);
    end
    in_val = 1'b0; out_rdy = 1'b1;
    expect_beat("bp.b1", 8'h0C, 7'd3, 8'hBB, 1'b0);
    check("bp.in_rdy_emit", in_rdy, 0);
    expect_beat("bp.b2", 8'h0C, 7'd3, 8'hCC, 1'b1);
    check("bp.done", out_val, 0);

    // reset in the middle of EMIT abandons the frame
    out_rdy = 1'b0;
    send(8'hA5); send(8'h05); send(8'h01); send(8'h77); send(8'h73);
    check("rst_emit.pre", out_val, 1);
    rst = 1'b1;
    #1;
    check("rst_emit.val", out_val, 0);
    check("rst_emit.in_rdy", in_rdy, 0);
    tick();
    rst = 1'b0;
    #1;
    check("rst_emit.in_rdy_after", in_rdy, 1);
    out_rdy = 1'b1;
    send(8'hA5); send(8'h09); send(8'h00); send(8'h09);
    expect_beat("rst_emit.next", 8'h09, 7'd0, 8'h00, 1'b1);

    // stalled frame: timeout only when the feature is built
    send(8'hA5); send(8'h01);
    repeat (15) tick();
    check("tmo.early", err_tmo, 0);
    tick();
    check("tmo.pulse", err_tmo, TMO_EN);
    tick();
    check("tmo.pulse_end", err_tmo, 0);
    send(8'h02); send(8'h10); send(8'h20); send(8'h33);
    check("tmo.after_val", out_val, !TMO_EN);
    drain();

    check("cnt.err_len", cnt_len, 2);
    check("cnt.err_chk", cnt_chk, 1);
    check("cnt.err_tmo", cnt_tmo, TMO_EN ? 1 : 0);
    check("cnt.clash", cnt_clash, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rx_frame_parser.md
RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 SHALL have parameter MAX_LEN, default 64: the largest payload length, in bytes, that is accepted.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 100000: the maximum idle gap, in clocks, allowed between bytes inside a frame.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port in_data, input, 8 bits: byte from the rx FIFO output.
REQ-006 SHALL have port in_val, input, 1 bit: in_data is valid.
REQ-007 SHALL have port in_rdy, output, 1 bit: the parser accepts in_data this cycle.
REQ-008 SHALL have port out_cmd, output, 8 bits: command byte of the frame being emitted.
REQ-009 SHALL have port out_len, output, 7 bits: payload length of the frame being emitted.
REQ-010 SHALL have port out_data, output, 8 bits: payload byte.
REQ-011 SHALL have port out_val, output, 1 bit: out_* outputs are valid.
REQ-012 SHALL have port out_rdy, input, 1 bit: the control logic accepts the current beat.
REQ-013 SHALL have port out_last, output, 1 bit: the current beat is the final beat of the frame.
REQ-014 SHALL have ports err_len, err_chk and err_tmo, each output, 1 bit: one-cycle error pulses.

Function
REQ-015 SHALL use the frame format: SOF 0xA5, CMD, LEN, LEN payload bytes, CHK; CHK is the XOR of CMD, LEN and all payload bytes.
REQ-016 SHALL implement states HUNT, CMD, LEN, PAYLOAD, CHK and EMIT; a byte transfers only when in_val and in_rdy are both high.
REQ-017 SHALL drive in_rdy high in HUNT through CHK and low in EMIT.
REQ-018 In HUNT, SHALL discard non-0xA5 bytes and go to CMD on 0xA5.
REQ-019 SHALL latch CMD and seed the running XOR with it, then go to LEN.
REQ-020 In LEN, SHALL pulse err_len and return to HUNT when LEN > MAX_LEN or LEN bit 7 is set; otherwise latch LEN, XOR it in, and go to PAYLOAD (LEN>0) or CHK (LEN=0).
REQ-021 In PAYLOAD, SHALL write each byte to an internal MAX_LEN x 8 buffer at the incrementing write index and XOR it in; after byte LEN-1, go to CHK.
REQ-022 In CHK, SHALL go to EMIT when the received byte equals the running XOR; otherwise pulse err_chk, go to HUNT, and emit nothing.
REQ-023 SHALL assert out_val the cycle after the CHK byte transfers, i.e. 1 clock of latency from the checksum to the first beat.
REQ-024 In EMIT, SHALL drive out_data from buffer[rd_idx], advance rd_idx on out_val&&out_rdy, assert out_last when rd_idx=LEN-1, and return to HUNT after the last beat transfers.
REQ-025 For LEN=0, SHALL emit exactly one beat with out_data=0x00 and out_last=1.
REQ-026 SHALL hold out_cmd, out_len, out_data and out_last stable while out_val&&!out_rdy, and SHALL NOT drop out_val until the beat is accepted.
REQ-027 SHALL accept no input during EMIT (backpressure only); the next frame's SOF is accepted in the cycle after the last beat transfers.
REQ-028 Error pulses SHALL last exactly one clock and SHALL never coincide with out_val.

Reset
REQ-029 On rst, SHALL immediately set state=HUNT, indices=0, XOR=0, out_val=0, out_last=0, in_rdy=0, and err_*=0.
REQ-030 SHALL drive in_rdy=1 in the first cycle after rst deasserts.
REQ-031 On rst during EMIT, SHALL abandon the frame without completing it; buffer contents need no clearing.

Configuration
REQ-032 SHALL implement the inter-byte timeout under macro RX_FRAME_TIMEOUT_EN.
REQ-033 With RX_FRAME_TIMEOUT_EN defined, in CMD, LEN, PAYLOAD and CHK, SHALL clear a counter on every transfer and increment it otherwise; on reaching TIMEOUT_CYCLES-1, SHALL pulse err_tmo and go to HUNT.
REQ-034 With RX_FRAME_TIMEOUT_EN defined, SHALL hold the counter at zero in HUNT and EMIT.
REQ-035 With RX_FRAME_TIMEOUT_EN undefined, SHALL not build the counter, SHALL tie err_tmo to 0, and a stalled frame SHALL wait indefinitely.

Verification
REQ-036 Bytes A5 01 02 10 20 33, out_rdy=1 -> two beats (0x10, then 0x20 with out_last); out_cmd=0x01, out_len=2; no errors.
REQ-037 Bytes A5 01 02 10 20 34 -> err_chk pulses once, no out_val; a following valid frame is emitted correctly.
REQ-038 Bytes A5 07 41 (LEN 65 > 64) -> err_len pulses; payload bytes are hunted as noise, nothing is emitted.
REQ-039 Bytes A5 09 00 09 -> one beat with out_data=0x00, out_last=1, out_cmd=0x09.
REQ-040 Valid 3-byte frame with out_rdy toggling 1-0-0-1 -> outputs stay stable while stalled, in_rdy=0 throughout EMIT, and all beats are delivered in order.
REQ-041 RX_FRAME_TIMEOUT_EN with TIMEOUT_CYCLES=16: A5 01 then 16 idle cycles -> err_tmo pulses once and the state returns to HUNT; without the macro, there is no pulse.
